// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// Requester IDs double as the round-robin pointer encoding.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 8;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per physical register plus the
// out-of-range address check shared by issue-side sets and accepted writebacks.
module regfile_scoreboard #(
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
    parameter int unsigned NREGS  = regfile_pkg::NREGS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_valid_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_valid_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic              acc_valid_i,
    input  logic [ADDR_W-1:0] acc_addr_i,
    output logic              acc_in_range_o,
    output logic [NREGS-1:0]  busy_mask_o,
    output logic              addr_err_o
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NREGS);

    logic             set_ok;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             err_q, err_d;

    assign set_ok         = {1'b0, set_addr_i} < LIMIT;
    assign acc_in_range_o = {1'b0, acc_addr_i} < LIMIT;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            set_mask[i] = set_valid_i && set_ok && (set_addr_i == ADDR_W'(i));
            clr_mask[i] = clr_valid_i && (clr_addr_i == ADDR_W'(i));
        end
        // Set is applied after clear so a same-edge set keeps the bit high.
        busy_d = (busy_q & ~clr_mask) | set_mask;
        err_d  = (set_valid_i && !set_ok) || (acc_valid_i && !acc_in_range_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask_o = busy_q;
    assign addr_err_o  = err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter sharing the single regfile write port between
// the ALU and load unit, with a registered WE3/A3/WD3 stage and pending scoreboard.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
    parameter int unsigned NREGS  = regfile_pkg::NREGS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              wb_hold,
    input  logic              sb_set_valid,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic [NREGS-1:0]  busy_mask,
    output logic              addr_err
);
    import regfile_pkg::*;

    req_id_e           last_grant_q, last_grant_d;
    wb_req_t           sel;
    logic              xfer;
    logic              acc_ok;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!wb_hold) begin
            if (req0_valid && req1_valid) begin
                req0_ready = (last_grant_q == REQ_LOAD);
                req1_ready = (last_grant_q == REQ_ALU);
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    always_comb begin
        sel = '0;
        if (req0_ready) begin
            sel = '{valid: req0_valid, addr: req0_addr, data: req0_data};
        end else if (req1_ready) begin
            sel = '{valid: req1_valid, addr: req1_addr, data: req1_data};
        end
        xfer = sel.valid;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (req0_ready)      last_grant_d = REQ_ALU;
        else if (req1_ready) last_grant_d = REQ_LOAD;
        // Out-of-range transfers are consumed but never reach the write port.
        we_d = xfer && acc_ok;
        a3_d = we_d ? sel.addr : a3_q;
        wd_d = we_d ? sel.data : wd_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant_q <= REQ_LOAD;
            we_q         <= 1'b0;
            a3_q         <= '0;
            wd_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            a3_q         <= a3_d;
            wd_q         <= wd_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk_i          (CLK),
        .rst_i          (RST),
        .set_valid_i    (sb_set_valid),
        .set_addr_i     (sb_set_addr),
        .clr_valid_i    (we_q),
        .clr_addr_i     (a3_q),
        .acc_valid_i    (xfer),
        .acc_addr_i     (sel.addr),
        .acc_in_range_o (acc_ok),
        .busy_mask_o    (busy_mask),
        .addr_err_o     (addr_err)
    );

    assign WE3 = we_q;
    assign A3  = a3_q;
    assign WD3 = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle-by-cycle vector table run from
// reset, followed by a hand-written reset-with-transfer-in-flight sequence.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        wb_hold;
    logic        sb_set_valid;
    logic [4:0]  sb_set_addr;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [7:0]  busy_mask;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter #(
        .DATA_W (32),
        .ADDR_W (5),
        .NREGS  (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .wb_hold      (wb_hold),
        .sb_set_valid (sb_set_valid),
        .sb_set_addr  (sb_set_addr),
        .WE3          (WE3),
        .A3           (A3),
        .WD3          (WD3),
        .busy_mask    (busy_mask),
        .addr_err     (addr_err)
    );

    typedef struct {
        logic        hold;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        sv;
        logic [4:0]  sa;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [7:0]  busy;
        logic        err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(logic hold, logic v0, logic [4:0] a0, logic [31:0] d0,
                                logic v1, logic [4:0] a1, logic [31:0] d1,
                                logic sv, logic [4:0] sa, logic r0, logic r1,
                                logic we, logic [4:0] a3, logic [31:0] wd,
                                logic [7:0] busy, logic err);
        vec_t v;
        v.hold = hold; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.sv = sv; v.sa = sa;
        v.r0 = r0; v.r1 = r1; v.we = we; v.a3 = a3; v.wd = wd;
        v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wb_hold = 0; req0_valid = 0; req1_valid = 0; sb_set_valid = 0;
        req0_addr = '0; req0_data = '0; req1_addr = '0; req1_data = '0; sb_set_addr = '0;
    endtask

    initial begin
        // hold v0 a0 d0            v1 a1 d1            sv sa   r0 r1  we a3 wd            busy   err
        vecs[0]  = mk(0, 1, 3, 32'hDEADBEEF, 0, 0, 0,       0, 0,  1, 0,  1, 3, 32'hDEADBEEF, 8'h00, 0);
        vecs[1]  = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0,  0, 3, 32'hDEADBEEF, 8'h00, 0);
        vecs[2]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 1,  1, 2, 32'h22,       8'h00, 0);
        vecs[3]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  1, 0,  1, 1, 32'h11,       8'h00, 0);
        vecs[4]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 1,  1, 2, 32'h22,       8'h00, 0);
        vecs[5]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  1, 0,  1, 1, 32'h11,       8'h00, 0);
        vecs[6]  = mk(0, 0, 0, 0,            0, 0, 0,       1, 5,  0, 0,  0, 1, 32'h11,       8'h20, 0);
        vecs[7]  = mk(0, 0, 0, 0,            1, 5, 32'h55,  0, 0,  0, 1,  1, 5, 32'h55,       8'h20, 0);
        vecs[8]  = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0,  0, 5, 32'h55,       8'h00, 0);
        vecs[9]  = mk(0, 1, 4, 32'h44,       0, 0, 0,       1, 4,  1, 0,  1, 4, 32'h44,       8'h10, 0);
        vecs[10] = mk(0, 0, 0, 0,            0, 0, 0,       1, 4,  0, 0,  0, 4, 32'h44,       8'h10, 0);
        vecs[11] = mk(0, 1, 4, 32'h45,       0, 0, 0,       0, 0,  1, 0,  1, 4, 32'h45,       8'h10, 0);
        vecs[12] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0,  0, 4, 32'h45,       8'h00, 0);
        vecs[13] = mk(0, 1, 9, 32'h1,        0, 0, 0,       0, 0,  1, 0,  0, 4, 32'h45,       8'h00, 1);
        vecs[14] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0,  0, 4, 32'h45,       8'h00, 0);
        vecs[15] = mk(0, 0, 0, 0,            0, 0, 0,       1, 12, 0, 0,  0, 4, 32'h45,       8'h00, 1);
        vecs[16] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0,  0, 4, 32'h45,       8'h00, 0);
        vecs[17] = mk(1, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 0,  0, 4, 32'h45,       8'h00, 0);
        vecs[18] = mk(1, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 0,  0, 4, 32'h45,       8'h00, 0);
        vecs[19] = mk(1, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 0,  0, 4, 32'h45,       8'h00, 0);

        idle_inputs();
        RST = 1;
        tick();
        tick();
        RST = 0;
        chk("reset WE3", 32'(WE3), 0);
        chk("reset A3", 32'(A3), 0);
        chk("reset WD3", WD3, 0);
        chk("reset busy_mask", 32'(busy_mask), 0);
        chk("reset addr_err", 32'(addr_err), 0);

        for (int i = 0; i < NV; i++) begin
            wb_hold      = vecs[i].hold;
            req0_valid   = vecs[i].v0;
            req0_addr    = vecs[i].a0;
            req0_data    = vecs[i].d0;
            req1_valid   = vecs[i].v1;
            req1_addr    = vecs[i].a1;
            req1_data    = vecs[i].d1;
            sb_set_valid = vecs[i].sv;
            sb_set_addr  = vecs[i].sa;
            #1;
            chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].r1));
            tick();
            chk($sformatf("v%0d WE3", i), 32'(WE3), 32'(vecs[i].we));
            chk($sformatf("v%0d A3", i), 32'(A3), 32'(vecs[i].a3));
            chk($sformatf("v%0d WD3", i), WD3, vecs[i].wd);
            chk($sformatf("v%0d busy_mask", i), 32'(busy_mask), 32'(vecs[i].busy));
            chk($sformatf("v%0d addr_err", i), 32'(addr_err), 32'(vecs[i].err));
        end

        // Release hold: pointer is at req0, so req1 wins; reset lands on the in-flight write.
        wb_hold = 0; sb_set_valid = 1; sb_set_addr = 3;
        #1;
        chk("release req0_ready", 32'(req0_ready), 0);
        chk("release req1_ready", 32'(req1_ready), 1);
        tick();
        chk("inflight WE3", 32'(WE3), 1);
        chk("inflight A3", 32'(A3), 2);
        chk("inflight busy_mask", 32'(busy_mask), 32'h08);
        idle_inputs();
        RST = 1;
        tick();
        RST = 0;
        chk("midrst WE3", 32'(WE3), 0);
        chk("midrst A3", 32'(A3), 0);
        chk("midrst WD3", WD3, 0);
        chk("midrst busy_mask", 32'(busy_mask), 0);
        chk("midrst addr_err", 32'(addr_err), 0);
        req0_valid = 1; req0_addr = 1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 2; req1_data = 32'h22;
        #1;
        chk("postrst req0_ready", 32'(req0_ready), 1);
        chk("postrst req1_ready", 32'(req1_ready), 0);
        tick();
        chk("postrst WE3", 32'(WE3), 1);
        chk("postrst A3", 32'(A3), 1);
        chk("postrst WD3", WD3, 32'h11);
        idle_inputs();
        tick();
        chk("postrst WE3 drop", 32'(WE3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
